// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - RV32I load/store port in front of the SDRAM controller data interface
`timescale 1ns/1ps
module lsu_mem_port #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_data,
  output logic              resp_misaligned,
  output logic              resp_fault,
  output logic              data_enable,
  input  logic              data_valid,
  output logic [1:0]        data_oplen,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic              data_rw,
  input  logic [31:0]       data_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t            state_q;
  logic              req_ready_q, resp_valid_q, resp_mis_q, resp_fault_q;
  logic              data_enable_q, data_rw_q, store_q;
  logic [4:0]        resp_rd_q, rd_q;
  logic [31:0]       resp_data_q, data_wdata_q;
  logic [1:0]        data_oplen_q, off_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] data_addr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              f3_bad, misal, range_bad, timeout;
  logic [31:0]       wdata_d, rdata_d;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rd         = resp_rd_q;
  assign resp_data       = resp_data_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_fault      = resp_fault_q;
  assign data_enable     = data_enable_q;
  assign data_oplen      = data_oplen_q;
  assign data_addr       = data_addr_q;
  assign data_wdata      = data_wdata_q;
  assign data_rw         = data_rw_q;

  // Last counted cycle before the controller is given up on
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Request legality checks and store lane replication from the live request
  always_comb begin
    f3_bad    = req_store ? (req_funct3 >= 3'd3)
                          : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
    misal     = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    range_bad = |req_addr[31:ADDR_W];
    case (req_funct3[1:0])
      2'd0:    wdata_d = {4{req_wdata[7:0]}};
      2'd1:    wdata_d = {2{req_wdata[15:0]}};
      default: wdata_d = req_wdata;
    endcase
  end

  // Load lane extraction and sign/zero extension from the controller word
  always_comb begin
    ld_byte = data_rdata[{off_q, 3'b000} +: 8];
    ld_half = data_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    rdata_d = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    rdata_d = {{16{ld_half[15]}}, ld_half};
      3'd4:    rdata_d = {24'd0, ld_byte};
      3'd5:    rdata_d = {16'd0, ld_half};
      default: rdata_d = data_rdata;
    endcase
  end

  // Request FSM: accept, issue one controller strobe, wait out busy period, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rd_q     <= '0;
      resp_data_q   <= '0;
      resp_mis_q    <= 1'b0;
      resp_fault_q  <= 1'b0;
      data_enable_q <= 1'b0;
      data_rw_q     <= 1'b0;
      data_oplen_q  <= '0;
      data_addr_q   <= '0;
      data_wdata_q  <= '0;
      cnt_q         <= '0;
      store_q       <= 1'b0;
      funct3_q      <= '0;
      off_q         <= '0;
      rd_q          <= '0;
    end else begin
      data_enable_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            store_q     <= req_store;
            funct3_q    <= req_funct3;
            off_q       <= req_addr[1:0];
            rd_q        <= req_rd;
            cnt_q       <= '0;
            if (f3_bad || misal || range_bad) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rd_q    <= req_store ? 5'd0 : req_rd;
              resp_data_q  <= '0;
              resp_mis_q   <= !f3_bad && misal;
              resp_fault_q <= f3_bad || (!misal && range_bad);
            end else begin
              state_q      <= ISSUE;
              data_addr_q  <= req_addr[ADDR_W-1:0];
              data_oplen_q <= req_funct3[1:0];
              data_rw_q    <= req_store;
              data_wdata_q <= wdata_d;
            end
          end
        end
        ISSUE, WAIT_BUSY, WAIT_DONE: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rd_q    <= store_q ? 5'd0 : rd_q;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b1;
          end else if (state_q == ISSUE) begin
            if (data_valid) begin
              data_enable_q <= 1'b1;
              state_q       <= WAIT_BUSY;
            end
          end else if (state_q == WAIT_BUSY) begin
            if (!data_valid) state_q <= WAIT_DONE;
          end else if (data_valid) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rd_q    <= store_q ? 5'd0 : rd_q;
            resp_data_q  <= store_q ? 32'd0 : rdata_d;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_rd_q    <= '0;
          resp_data_q  <= '0;
          resp_mis_q   <= 1'b0;
          resp_fault_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store stage sitting directly upstream of the SDRAM controller's data port.
- Accepts one RV32I load/store per request from the execute stage.
- Checks alignment, funct3 legality and address range; lane-shifts store data.
- Drives the controller's data_* handshake, then extracts and sign/zero-extends load data and returns a one-cycle response to writeback.
- Blocking: one request in flight.

Parameters:
TIMEOUT_CYCLES, 64, cycles allowed from issue to controller completion before fault response.
ADDR_W, 25, controller byte-address width; req_addr bits above ADDR_W must be zero.

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  1  request present
req_ready  out  1  LSU idle, request accepted when req_valid&&req_ready
req_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I width/sign code
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
req_rd  in  5  load destination register
resp_valid  out  1  one-cycle response pulse
resp_rd  out  5  echoed req_rd (0 for stores)
resp_data  out  32  extended load data (0 for stores/faults)
resp_misaligned  out  1  alignment fault
resp_fault  out  1  illegal funct3, out-of-range address, or timeout
data_enable  out  1  controller request strobe
data_valid  in  1  controller idle/done
data_oplen  out  2  0=byte, 1=half, 2=word
data_addr  out  ADDR_W  byte address to controller
data_wdata  out  32  lane-positioned store data
data_rw  out  1  1=write, 0=read
data_rdata  in  32  aligned word containing addressed bytes, valid when data_valid rises

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_*=0, data_enable=0, data_rw=0, data_oplen=0, data_addr=0, data_wdata=0, timeout counter 0.
- States and transitions:
  - IDLE: req_ready=1. On accept, latch all req_* fields.
    - Error check priority: funct3 illegal (loads 3,6,7; stores >=3) -> fault; else misaligned (half with addr[0]; word with addr[1:0]!=0) -> misaligned; else addr[31:ADDR_W]!=0 -> fault.
    - Any error -> RESP with no memory access. Otherwise -> ISSUE.
  - ISSUE: assert data_enable for exactly one cycle, on the first cycle data_valid=1, with data_addr=addr[ADDR_W-1:0], data_oplen=funct3[1:0], data_rw=req_store. Then -> WAIT_BUSY. Stays in ISSUE while data_valid=0.
  - WAIT_BUSY: wait for data_valid=0 -> WAIT_DONE.
  - WAIT_DONE: wait for data_valid=1. On that cycle, capture data_rdata -> RESP.
  - RESP: resp_valid=1 for one cycle -> IDLE. No backpressure on the response.
- Timeout: counter resets on entry to ISSUE and increments in ISSUE/WAIT_BUSY/WAIT_DONE. At TIMEOUT_CYCLES -> RESP with resp_fault=1, resp_data=0. A late controller completion is ignored.
- Store lanes: SB replicates byte to all 4 lanes; SH replicates half to both halves; SW passes through. data_wdata is held stable from ISSUE until RESP.
- Load extract: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Latency: legal access = 1 (accept) + ISSUE + controller busy period + 1 (RESP). Error = accept at T, resp_valid at T+1.
- req_ready is low from the cycle after accept until IDLE re-entry. Back-to-back: new accept is possible the cycle after the RESP pulse.
- Reset mid-operation: everything returns to reset values immediately. An outstanding controller op is abandoned, and no response is emitted.

Test Plan:
- LW x3, addr 0x100, data_rdata=0xDEADBEEF; controller drops valid 1 cycle after enable, raises it 8 cycles later -> one data_enable pulse, oplen=2, rw=0, resp_valid 1 cycle after valid rise, resp_data=0xDEADBEEF, resp_rd=3.
- LB addr 0x103 with rdata=0x80112233 -> resp_data=0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x00008011.
- SB addr 0x41, wdata=0x12345621 -> data_wdata=0x21212121, oplen=0, rw=1, data_addr=0x41; resp_data=0, resp_rd=0.
- LW addr 0x102 -> no data_enable, resp_valid at T+1, resp_misaligned=1. funct3=3 load -> resp_fault=1. Addr 0x0200_0000 -> resp_fault=1.
- Controller holds data_valid=0 at issue for 3 cycles -> data_enable asserted only after valid=1. Controller never completes -> resp_fault=1 exactly TIMEOUT_CYCLES after ISSUE entry.
- rst_n low during WAIT_DONE -> outputs at reset values asynchronously, no resp_valid, req_ready=1 after release.
